// File: rtl/trace_scheduler_pkg.sv
// Shared types and defaults for the per-frame trace scheduler.
package trace_scheduler_pkg;

    localparam int DEF_COL_W    = 10;
    localparam int DEF_HEIGHT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Result FIFO entry layout: {col, side, height}
    function automatic int entry_width(input int col_w, input int height_w);
        return col_w + 1 + height_w;
    endfunction

endpackage

// File: rtl/trace_scheduler_fifo.sv
// Small synchronous FIFO for tracer results: count output, combinational head.
module trace_scheduler_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg];
    assign count   = count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/trace_scheduler.sv
// Issues one tracer job per column on each VBLANK rising edge and drains
// results into the trace buffer whenever the display is not reading it.
module trace_scheduler
    import trace_scheduler_pkg::*;
#(
    parameter int COL_FIRST  = 0,
    parameter int COL_LAST   = 639,
    parameter int FIFO_DEPTH = 4,
    parameter int COL_W      = DEF_COL_W,
    parameter int HEIGHT_W   = DEF_HEIGHT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                visible,
    input  logic                vblank,
    input  logic [COL_W-1:0]    h,
    output logic                trc_start,
    output logic [COL_W-1:0]    trc_col,
    input  logic                trc_done,
    input  logic                trc_side,
    input  logic [HEIGHT_W-1:0] trc_height,
    output logic [COL_W-1:0]    buf_addr,
    output logic                buf_we,
    output logic                buf_side,
    output logic [HEIGHT_W-1:0] buf_height,
    output logic                pass_busy,
    output logic                pass_done,
    output logic                overrun
);

    localparam int ENTRY_W = entry_width(COL_W, HEIGHT_W);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [COL_W-1:0] COL_FIRST_V = COL_W'(COL_FIRST);
    localparam logic [COL_W-1:0] COL_LAST_V  = COL_W'(COL_LAST);

    state_t              state_reg;
    state_t              state_next;
    logic [COL_W-1:0]    col_reg;
    logic                vblank_q_reg;
    logic                overrun_reg;

    logic                frame_edge;
    logic                space;
    logic                push;
    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [COL_W-1:0]    head_col;
    logic                head_side;
    logic [HEIGHT_W-1:0] head_height;

    assign frame_edge  = vblank & ~vblank_q_reg;
    assign space       = (fifo_count < DEPTH_CNT);
    assign push        = (state_reg == ST_WAIT) & trc_done;
    assign push_data   = {col_reg, trc_side, trc_height};
    assign head_col    = head[ENTRY_W-1 -: COL_W];
    assign head_side   = head[HEIGHT_W];
    assign head_height = head[HEIGHT_W-1:0];

    trace_scheduler_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (buf_we),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            col_reg      <= COL_FIRST_V;
            vblank_q_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            vblank_q_reg <= vblank;
            if (state_reg == ST_IDLE) begin
                if (frame_edge) begin
                    col_reg     <= COL_FIRST_V;
                    overrun_reg <= 1'b0;
                end
            end else if (frame_edge || visible) begin
                overrun_reg <= 1'b1;
            end
            if (push && (col_reg != COL_LAST_V)) col_reg <= col_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (frame_edge) state_next = ST_ISSUE;
            ST_ISSUE: if (space)      state_next = ST_WAIT;
            ST_WAIT:  if (trc_done)   state_next = (col_reg == COL_LAST_V) ? ST_FLUSH : ST_ISSUE;
            ST_FLUSH: if (fifo_empty) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Empty FIFO presents zeros so idle outputs are clean rather than stale.
    always_comb begin
        trc_start  = (state_reg == ST_ISSUE) & space;
        trc_col    = col_reg;
        pass_busy  = (state_reg != ST_IDLE);
        pass_done  = (state_reg == ST_FLUSH) & fifo_empty;
        overrun    = overrun_reg;
        buf_we     = ~visible & ~fifo_empty;
        buf_addr   = visible ? h : (fifo_empty ? '0 : head_col);
        buf_side   = ~fifo_empty & head_side;
        buf_height = fifo_empty ? '0 : head_height;
    end

endmodule
